onehot_grant_decoder: RTL and testbench

//   Inverse of the priority encoder: accepts a binary index (e.g. encoded_out/valid from the

---
 rtl/onehot_grant_decoder_if.sv | 25 ++
 rtl/onehot_grant_decoder.sv | 121 ++++++++++++
 tb/tb_onehot_grant_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_grant_decoder_if.sv
// Grant-issue bus: index handshake from the priority encoder, early release from the
// requester, and the registered one-hot grant with its status outputs.
interface onehot_grant_decoder_if #(
  parameter int N_OUT = 8,
  parameter int IDX_W = $clog2(N_OUT)
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_index;
  logic             release_i;
  logic [N_OUT-1:0] grant;
  logic             grant_valid;
  logic             err_idx;
  logic [7:0]       grant_count;

  modport master (
    output in_valid, in_index, release_i,
    input  in_ready, grant, grant_valid, err_idx, grant_count
  );

  modport slave (
    input  in_valid, in_index, release_i,
    output in_ready, grant, grant_valid, err_idx, grant_count
  );
endinterface

// File: rtl/onehot_grant_decoder.sv
// Grant-issue stage: decodes an accepted binary index into a registered one-hot grant,
// holds it for up to HOLD_CYCLES (or until released), then inserts a one-cycle idle gap.
module onehot_grant_decoder #(
  parameter int N_OUT       = 8,
  parameter int IDX_W       = $clog2(N_OUT),
  parameter int HOLD_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  onehot_grant_decoder_if.slave bus
);

  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_p0, state_p1;
  logic [N_OUT-1:0] grant_p0, grant_p1;
  logic             vld_p0, vld_p1;
  logic             err_p0, err_p1;
  logic [CNT_W-1:0] hold_p0, hold_p1;
  logic [7:0]       count_p0, count_p1;

  logic             idx_ok;
  logic             xfer;
  logic [N_OUT-1:0] decoded;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A full power-of-two index range can never be out of bounds.
  generate
    if (N_OUT == (1 << IDX_W)) begin : g_full_range
      assign idx_ok = 1'b1;
    end else begin : g_part_range
      localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(N_OUT);
      assign idx_ok = ({1'b0, bus.in_index} < LIMIT);
    end
  endgenerate

  assign bus.in_ready = (state_p1 == IDLE) && rst_n;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign decoded      = {{(N_OUT-1){1'b0}}, 1'b1} << bus.in_index;

  // Stage p0: next-state and next-output decode
  always_comb begin
    state_p0 = state_p1;
    grant_p0 = grant_p1;
    vld_p0   = vld_p1;
    err_p0   = 1'b0;
    hold_p0  = hold_p1;
    count_p0 = count_p1;
    unique case (state_p1)
      IDLE: begin
        grant_p0 = '0;
        vld_p0   = 1'b0;
        if (xfer) begin
          if (idx_ok) begin
            grant_p0 = decoded;
            vld_p0   = 1'b1;
            hold_p0  = HOLD_LOAD;
            count_p0 = sat_inc(count_p1);
            state_p0 = GRANT;
          end else begin
            err_p0 = 1'b1;
          end
        end
      end
      GRANT: begin
        if (bus.release_i || (hold_p1 == '0)) begin
          grant_p0 = '0;
          vld_p0   = 1'b0;
          state_p0 = GAP;
        end else begin
          hold_p0 = hold_p1 - 1'b1;
        end
      end
      GAP: begin
        grant_p0 = '0;
        vld_p0   = 1'b0;
        state_p0 = IDLE;
      end
      default: begin
        grant_p0 = '0;
        vld_p0   = 1'b0;
        state_p0 = IDLE;
      end
    endcase
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      grant_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      hold_p1  <= '0;
      count_p1 <= '0;
    end else begin
      state_p1 <= state_p0;
      grant_p1 <= grant_p0;
      vld_p1   <= vld_p0;
      err_p1   <= err_p0;
      hold_p1  <= hold_p0;
      count_p1 <= count_p0;
    end
  end

  assign bus.grant       = grant_p1;
  assign bus.grant_valid = vld_p1;
  assign bus.err_idx     = err_p1;
  assign bus.grant_count = count_p1;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed bench for onehot_grant_decoder: an 8-output instance for the main scenarios
// and a 6-output instance for out-of-range indices.
module tb_onehot_grant_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  onehot_grant_decoder_if #(.N_OUT(8)) bus8 ();
  onehot_grant_decoder_if #(.N_OUT(6)) bus6 ();

  onehot_grant_decoder #(.N_OUT(8), .HOLD_CYCLES(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  onehot_grant_decoder #(.N_OUT(6), .HOLD_CYCLES(4)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(bus8.grant) || (bus8.grant_valid !== (|bus8.grant)) ||
          (bus8.err_idx && bus8.grant_valid)) begin
        errors++;
        $display("FAIL invariant8 grant=%h grant_valid=%b err_idx=%b", bus8.grant, bus8.grant_valid, bus8.err_idx);
      end
      checks++;
      if (!$onehot0(bus6.grant) || (bus6.grant_valid !== (|bus6.grant)) ||
          (bus6.err_idx && bus6.grant_valid)) begin
        errors++;
        $display("FAIL invariant6 grant=%h grant_valid=%b err_idx=%b", bus6.grant, bus6.grant_valid, bus6.err_idx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_index = '0; bus8.release_i = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_index = '0; bus6.release_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_index = 3'd2; bus8.release_i = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_index = '0; bus6.release_i = 1'b0;
    repeat (3) step();
    checks++; if (bus8.grant !== 8'h00) begin errors++; $display("FAIL reset_grant got=%h exp=00", bus8.grant); end
    checks++; if (bus8.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv got=%b exp=0", bus8.grant_valid); end
    checks++; if (bus8.grant_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus8.grant_count); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus8.in_ready); end
    bus8.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", bus8.in_ready); end
  endtask

  task automatic test_basic();
    bus8.in_valid = 1'b1; bus8.in_index = 3'd3;
    step();
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus8.grant !== 8'b0000_1000) begin errors++; $display("FAIL basic_grant[%0d] got=%h exp=08", i, bus8.grant); end
      checks++; if (bus8.grant_valid !== 1'b1) begin errors++; $display("FAIL basic_gv[%0d] got=%b exp=1", i, bus8.grant_valid); end
      checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready[%0d] got=%b exp=0", i, bus8.in_ready); end
      step();
    end
    checks++; if (bus8.grant !== 8'h00) begin errors++; $display("FAIL basic_gap_grant got=%h exp=00", bus8.grant); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL basic_gap_ready got=%b exp=0", bus8.in_ready); end
    step();
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got=%b exp=1", bus8.in_ready); end
    checks++; if (bus8.grant_count !== 8'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", bus8.grant_count); end
  endtask

  task automatic test_early_release();
    bus8.in_valid = 1'b1; bus8.in_index = 3'd7;
    step();
    bus8.in_valid = 1'b0;
    checks++; if (bus8.grant !== 8'h80) begin errors++; $display("FAIL early_grant1 got=%h exp=80", bus8.grant); end
    step();
    checks++; if (bus8.grant !== 8'h80) begin errors++; $display("FAIL early_grant2 got=%h exp=80", bus8.grant); end
    bus8.release_i = 1'b1;
    step();
    bus8.release_i = 1'b0;
    checks++; if (bus8.grant !== 8'h00) begin errors++; $display("FAIL early_gap_grant got=%h exp=00", bus8.grant); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL early_gap_ready got=%b exp=0", bus8.in_ready); end
    step();
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL early_idle_ready got=%b exp=1", bus8.in_ready); end
    checks++; if (bus8.grant_count !== 8'd2) begin errors++; $display("FAIL early_count got=%0d exp=2", bus8.grant_count); end
  endtask

  task automatic test_back_to_back();
    int   idx;
    int   last;
    int   cyc;
    logic rdy;
    do_reset();
    idx = 0; last = 0; cyc = 0;
    bus8.in_valid = 1'b1; bus8.in_index = 3'd0;
    while (idx < 8 && cyc < 200) begin
      rdy = bus8.in_ready;
      step();
      cyc++;
      if (rdy) begin
        checks++;
        if (bus8.grant !== (8'h01 << idx)) begin
          errors++; $display("FAIL b2b_grant idx=%0d got=%h exp=%h", idx, bus8.grant, 8'h01 << idx);
        end
        if (idx > 0) begin
          checks++;
          if (cyc - last != 6) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", idx, cyc - last); end
        end
        last = cyc;
        idx++;
        if (idx < 8) bus8.in_index = 3'(idx);
        else         bus8.in_valid = 1'b0;
      end
    end
    bus8.in_valid = 1'b0;
    checks++; if (idx != 8) begin errors++; $display("FAIL b2b_timeout granted=%0d exp=8", idx); end
    repeat (6) step();
    checks++; if (bus8.grant_count !== 8'd8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", bus8.grant_count); end
  endtask

  task automatic test_bad_index();
    bus6.in_valid = 1'b1; bus6.in_index = 3'd6;
    step();
    bus6.in_valid = 1'b0;
    checks++; if (bus6.err_idx !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", bus6.err_idx); end
    checks++; if (bus6.grant !== 6'h00) begin errors++; $display("FAIL bad_grant got=%h exp=00", bus6.grant); end
    checks++; if (bus6.grant_count !== 8'd0) begin errors++; $display("FAIL bad_count got=%0d exp=0", bus6.grant_count); end
    checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got=%b exp=1", bus6.in_ready); end
    step();
    checks++; if (bus6.err_idx !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got=%b exp=0", bus6.err_idx); end
    bus6.in_valid = 1'b1; bus6.in_index = 3'd5;
    step();
    bus6.in_valid = 1'b0;
    checks++; if (bus6.grant !== 6'b10_0000) begin errors++; $display("FAIL good6_grant got=%h exp=20", bus6.grant); end
    checks++; if (bus6.err_idx !== 1'b0) begin errors++; $display("FAIL good6_err got=%b exp=0", bus6.err_idx); end
    checks++; if (bus6.grant_count !== 8'd1) begin errors++; $display("FAIL good6_count got=%0d exp=1", bus6.grant_count); end
    repeat (6) step();
    bus6.in_valid = 1'b1; bus6.in_index = 3'd7;
    step();
    bus6.in_valid = 1'b0;
    checks++; if (bus6.err_idx !== 1'b1) begin errors++; $display("FAIL bad7_err got=%b exp=1", bus6.err_idx); end
    checks++; if (bus6.grant_count !== 8'd1) begin errors++; $display("FAIL bad7_count got=%0d exp=1", bus6.grant_count); end
  endtask

  task automatic test_reset_mid_grant();
    bus8.in_valid = 1'b1; bus8.in_index = 3'd2;
    step();
    bus8.in_valid = 1'b0;
    checks++; if (bus8.grant !== 8'h04) begin errors++; $display("FAIL midrst_grant1 got=%h exp=04", bus8.grant); end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus8.grant !== 8'h00) begin errors++; $display("FAIL midrst_grant got=%h exp=00", bus8.grant); end
    checks++; if (bus8.grant_valid !== 1'b0) begin errors++; $display("FAIL midrst_gv got=%b exp=0", bus8.grant_valid); end
    checks++; if (bus8.grant_count !== 8'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", bus8.grant_count); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus8.in_ready); end
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    bus8.in_valid = 1'b1; bus8.in_index = 3'd5;
    step();
    bus8.in_valid = 1'b0;
    checks++; if (bus8.grant !== 8'h20) begin errors++; $display("FAIL midrst_regrant got=%h exp=20", bus8.grant); end
    checks++; if (bus8.grant_count !== 8'd1) begin errors++; $display("FAIL midrst_recount got=%0d exp=1", bus8.grant_count); end
  endtask

  task automatic test_saturation();
    int   n;
    int   cyc;
    logic rdy;
    do_reset();
    n = 0; cyc = 0;
    bus8.in_valid = 1'b1; bus8.in_index = 3'd1; bus8.release_i = 1'b1;
    while (n < 300 && cyc < 2000) begin
      rdy = bus8.in_ready;
      step();
      cyc++;
      if (rdy) begin
        n++;
        if (n == 1 || n == 255 || n == 256 || n == 300) begin
          checks++;
          if (bus8.grant_count !== 8'((n > 255) ? 255 : n)) begin
            errors++; $display("FAIL sat_count n=%0d got=%0d exp=%0d", n, bus8.grant_count, (n > 255) ? 255 : n);
          end
        end
      end
    end
    bus8.in_valid = 1'b0; bus8.release_i = 1'b0;
    checks++; if (n != 300) begin errors++; $display("FAIL sat_timeout granted=%0d exp=300", n); end
    repeat (3) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_early_release();
    test_back_to_back();
    test_bad_index();
    test_reset_mid_grant();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
